// File: rtl/prod_accum_pkg.sv
// Shared widths, FSM state type and width helper for the 4x3 product accumulator.
package prod_accum_pkg;

  localparam int unsigned A_W = 4;
  localparam int unsigned B_W = 3;
  localparam int unsigned P_W = 7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/prod_accum_4x3_if.sv
// Operand input stream, frame result output stream and busy status for prod_accum_4x3.
interface prod_accum_4x3_if
  import prod_accum_pkg::*;
#(
  parameter int unsigned ACC_W = 10,
  parameter int unsigned CNT_W = 3
) ();

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   in_a;
  logic [B_W-1:0]   in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, busy
  );

endinterface

// File: rtl/multiplier_4x3.sv
// Combinational unsigned 4b x 3b multiplier producing a 7b product.
module multiplier_4x3
  import prod_accum_pkg::*;
(
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic [P_W-1:0] o_p
);

  assign o_p = P_W'(i_a) * P_W'(i_b);

endmodule

// File: rtl/prod_accum_4x3.sv
// Frame accumulator: registers operand pairs, multiplies them and sums products per frame,
// presenting the frame sum and beat count on a held valid/ready output.
module prod_accum_4x3
  import prod_accum_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned ACC_W     = 10,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  prod_accum_4x3_if.slave  bus
);

  if (ACC_W < P_W + clog2(FRAME_LEN)) begin : g_acc_w_chk
    $error("ACC_W too narrow for FRAME_LEN");
  end
  if (FRAME_LEN < 1 || FRAME_LEN >= (64'd1 << CNT_W)) begin : g_cnt_w_chk
    $error("CNT_W cannot hold FRAME_LEN");
  end

  state_e           r_state;
  logic [A_W-1:0]   r_a;
  logic [B_W-1:0]   r_b;
  logic             r_v;
  logic             r_final;
  logic             r_last_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_count;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_final;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [P_W-1:0]   w_prod;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_acc_sum;

  multiplier_4x3 u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  assign w_in_ready = (r_state != StHold) && !r_last_pending;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_final    = bus.in_last || (w_cnt_inc == CNT_W'(FRAME_LEN));
  assign w_prod_ext = {{(ACC_W - P_W){1'b0}}, w_prod};
  assign w_acc_sum  = r_acc + w_prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_a            <= '0;
      r_b            <= '0;
      r_v            <= 1'b0;
      r_final        <= 1'b0;
      r_last_pending <= 1'b0;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_out_valid    <= 1'b0;
      r_out_sum      <= '0;
      r_out_count    <= '0;
    end else begin
      // Stage 1: capture the accepted beat and count it.
      r_v <= w_accept;
      if (w_accept) begin
        r_a     <= bus.in_a;
        r_b     <= bus.in_b;
        r_final <= w_final;
        r_cnt   <= w_cnt_inc;
        if (w_final) begin
          r_last_pending <= 1'b1;
        end
      end

      // Stage 2: fold the product in; the final beat publishes and clears the frame.
      if (r_v) begin
        if (r_final) begin
          r_out_sum      <= w_acc_sum;
          r_out_count    <= r_cnt;
          r_out_valid    <= 1'b1;
          r_acc          <= '0;
          r_cnt          <= '0;
          r_last_pending <= 1'b0;
        end else begin
          r_acc <= w_acc_sum;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state <= StAccum;
          end
        end
        StAccum: begin
          if (r_v && r_final) begin
            r_state <= StHold;
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.busy      = (r_state != StIdle) || r_v;

endmodule
